// File: rtl/fifo_wr_arb_ctrl_pkg.sv
// Shared types and pointer/flag helpers for the single-clock FIFO write-arbitration controller.
// The pointer types are sized for the default fifo_mem address width.
package fifo_ctrl_pkg;

  localparam int ADDR_W = 3;

  typedef logic [ADDR_W:0] ptr_t;
  typedef logic [ADDR_W:0] count_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic is_empty(input ptr_t wptr, input ptr_t rptr);
    return wptr == rptr;
  endfunction

  // Full when indices match but the wrap bits differ.
  function automatic logic is_full(input ptr_t wptr, input ptr_t rptr);
    return (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Requester, read-side and fifo_mem-facing signals of the write-arbitration controller.
// slave = the controller, master = the surrounding system driving requests.
interface fifo_wr_arb_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REQ    = 2
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [GW-1:0]                 grant_id;
  logic                          rd_req;
  logic                          rd_valid;
  logic                          mem_w_en;
  logic                          mem_r_en;
  logic [ADDR_WIDTH:0]           mem_wptr;
  logic [ADDR_WIDTH:0]           mem_rptr;
  logic [DATA_WIDTH-1:0]         mem_data_in;
  logic                          mem_fifo_full;
  logic                          mem_fifo_empty;
  logic [ADDR_WIDTH:0]           count;
  logic                          almost_full;
  logic                          almost_empty;
  logic                          clr_err;
  logic                          underflow_err;

  modport slave (
    input  req_valid, req_data, rd_req, clr_err,
    output req_ready, grant_id, rd_valid, mem_w_en, mem_r_en, mem_wptr, mem_rptr,
           mem_data_in, mem_fifo_full, mem_fifo_empty, count, almost_full,
           almost_empty, underflow_err
  );

  modport master (
    output req_valid, req_data, rd_req, clr_err,
    input  req_ready, grant_id, rd_valid, mem_w_en, mem_r_en, mem_wptr, mem_rptr,
           mem_data_in, mem_fifo_full, mem_fifo_empty, count, almost_full,
           almost_empty, underflow_err
  );
endinterface

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans from the requester after the last grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_id
);

  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Pointer/flag controller for fifo_mem with round-robin arbitration of several writers.
// Flags, grant and memory strobes are combinational from the registered pointers.
module fifo_wr_arb_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int NUM_REQ    = 2,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arb_ctrl_if.slave bus
);

  localparam int GW    = $clog2(NUM_REQ);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  ptr_t                  wptr_reg;
  ptr_t                  rptr_reg;
  logic [GW-1:0]         last_reg;
  logic                  rd_valid_reg;
  logic                  underflow_reg;

  logic                  full;
  logic                  empty;
  count_t                occ;
  logic [NUM_REQ-1:0]    grant;
  logic [GW-1:0]         gid;
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign full  = is_full(wptr_reg, rptr_reg);
  assign empty = is_empty(wptr_reg, rptr_reg);
  assign occ   = wptr_reg - rptr_reg;

  // Masking requests with !full keeps req_ready low while the FIFO cannot accept.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
    .req      (bus.req_valid & {NUM_REQ{~full}}),
    .last     (last_reg),
    .grant    (grant),
    .grant_id (gid)
  );

  assign w_en = |(bus.req_valid & grant);
  assign r_en = bus.rd_req & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      last_reg      <= GW'(NUM_REQ - 1);
      rd_valid_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (w_en) begin
        wptr_reg <= wptr_reg + ptr_t'(1);
        last_reg <= gid;
      end
      if (r_en) begin
        rptr_reg <= rptr_reg + ptr_t'(1);
      end
      rd_valid_reg <= r_en;
      if (bus.rd_req && empty) begin
        underflow_reg <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready      = grant;
  assign bus.grant_id       = gid;
  assign bus.mem_w_en       = w_en;
  assign bus.mem_r_en       = r_en;
  assign bus.mem_wptr       = wptr_reg;
  assign bus.mem_rptr       = rptr_reg;
  assign bus.mem_data_in    = w_en ? slice[gid] : '0;
  assign bus.mem_fifo_full  = full;
  assign bus.mem_fifo_empty = empty;
  assign bus.count          = occ;
  assign bus.almost_full    = (occ >= count_t'(DEPTH - AF_MARGIN));
  assign bus.almost_empty   = (occ <= count_t'(AE_MARGIN));
  assign bus.rd_valid       = rd_valid_reg;
  assign bus.underflow_err  = underflow_reg;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based FIFO model.
module tb_fifo_wr_arb_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int NR    = 2;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  fifo_wr_arb_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for fifo_mem so read data can be checked end to end.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] data_out;
  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_wptr[AW-1:0]] <= bus.mem_data_in;
    if (bus.mem_r_en) data_out <= mem[bus.mem_rptr[AW-1:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] q[$];
  int            wcnt, rcnt, last, uf, exp_rv;
  logic [DW-1:0] exp_rd_data;
  logic [DW-1:0] dat [NR];
  logic [NR-1:0] pend;

  task automatic model_reset();
    q.delete();
    wcnt = 0; rcnt = 0; last = NR - 1; uf = 0; exp_rv = 0;
  endtask

  task automatic cycle(input logic [NR-1:0] v, input logic rd, input logic clr, input logic r);
    int g, idx, sz;
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] popped;
    int rv_n;
    @(negedge clk);
    bus.req_valid = v;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = dat[i];
    bus.rd_req  = rd;
    bus.clr_err = clr;
    rst = r;
    #1;
    sz = q.size();
    g = -1;
    if (sz < DEPTH) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (last + k) % NR;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? NR'(1 << g) : '0;
    exp_din   = (g >= 0) ? dat[g] : '0;
    check_eq("req_ready", bus.req_ready, exp_ready);
    check_eq("mem_w_en", bus.mem_w_en, g >= 0);
    if (g >= 0) check_eq("grant_id", bus.grant_id, g);
    check_eq("mem_data_in", bus.mem_data_in, exp_din);
    check_eq("mem_r_en", bus.mem_r_en, rd && sz != 0);
    check_eq("mem_wptr", bus.mem_wptr, wcnt % 16);
    check_eq("mem_rptr", bus.mem_rptr, rcnt % 16);
    check_eq("count", bus.count, sz);
    check_eq("full", bus.mem_fifo_full, sz == DEPTH);
    check_eq("empty", bus.mem_fifo_empty, sz == 0);
    check_eq("almost_full", bus.almost_full, sz >= DEPTH - AFM);
    check_eq("almost_empty", bus.almost_empty, sz <= AEM);
    check_eq("underflow_err", bus.underflow_err, uf);
    check_eq("rd_valid", bus.rd_valid, exp_rv);
    if (exp_rv != 0) check_eq("rd_data", data_out, exp_rd_data);

    if (r) begin
      model_reset();
      pend = '0;
    end else begin
      rv_n = 0;
      popped = exp_rd_data;
      if (rd && sz != 0) begin
        popped = q.pop_front();
        rv_n = 1;
        rcnt++;
      end
      if (g >= 0) begin
        q.push_back(dat[g]);
        wcnt++;
        last = g;
        dat[g] = dat[g] + 1;
      end
      if (rd && sz == 0) uf = 1;
      else if (clr) uf = 0;
      exp_rv = rv_n;
      exp_rd_data = popped;
      pend = v & ~exp_ready;
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rd_req    = 1'b0;
    bus.clr_err   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    pend = '0;
    dat[0] = 32'd1;
    dat[1] = 32'hA000_0001;

    // Fill from requester 0, one extra cycle to see full backpressure
    for (int i = 0; i < 9; i++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
    // Drain, plus one idle cycle for the last rd_valid
    for (int i = 0; i < 9; i++) cycle(2'b00, i < 8, 1'b0, 1'b0);
    // Underflow set, set beats clear, then clear
    cycle(2'b00, 1'b1, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    // Round-robin until full
    for (int i = 0; i < 8; i++) cycle(2'b11, 1'b0, 1'b0, 1'b0);
    // Full with both: read only
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0);
    // Count 4 with both: count unchanged
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0);
    // Reset held during traffic
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b1, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);

    // Random traffic; ungranted requesters keep their request up
    for (int n = 0; n < 3000; n++) begin
      logic [NR-1:0] v;
      logic rb;
      v = pend | NR'($urandom_range(0, (1 << NR) - 1));
      rb = ($urandom_range(0, 99) < 3);
      if (rb) begin
        for (int i = 0; i < 3; i++) cycle(v, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end else begin
        cycle(v, ($urandom_range(0, 99) < 45), ($urandom_range(0, 9) == 0), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
